// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Winner of one arbitration round: valid when any port requests, id = winning port.
    typedef struct packed {
        logic valid;
        logic id;
    } arb_gnt_t;

endpackage

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational winner pick between the two requesters.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 always wins a tie.
module arb_select
    import mem_arb_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic     rr_ptr_i,
`endif
    output arb_gnt_t gnt_o
);

    always_comb begin
        gnt_o.valid = req0_i | req1_i;
`ifdef ARB_ROUND_ROBIN_EN
        // rr_ptr_i names the favoured port; it only matters when both request.
        gnt_o.id    = (req0_i & req1_i) ? rr_ptr_i : req1_i;
`else
        gnt_o.id    = ~req0_i;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two requesters: arbitrate, hold mem_en MEM_LAT cycles, one-cycle ack.
// Tie-breaking is fixed priority unless ARB_ROUND_ROBIN_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1           // legal range 1..15
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              read_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in
);

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              en_q, en_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_q, rr_d;
`endif
    arb_gnt_t          pick;

    arb_select u_arb_select (
        .req0_i   (req0),
        .req1_i   (req1),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_ptr_i (rr_q),
`endif
        .gnt_o    (pick)
    );

    always_comb begin
        // NOTE: every next-state signal gets its default first, so no branch can infer a latch.
        state_d = state_q;
        lat_d   = lat_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        en_d    = en_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    gnt_d  = pick.id;
                    addr_d = pick.id ? addr1 : addr0;
                    rw_d   = pick.id ? rw1 : rw0;
                    if ((pick.id ? rw1 : rw0) == WR) begin
                        wdata_d = pick.id ? wdata1 : wdata0;
                    end
                    en_d    = 1'b1;
                    lat_d   = LAT_INIT;
                    state_d = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_d    = ~pick.id;
`endif
                end
            end
            ACCESS: begin
                if (lat_q != 4'd0) begin
                    lat_d = lat_q - 4'd1;
                end else begin
                    if (rw_q == RD) begin
                        rdata_d = data_in;
                    end
                    en_d    = 1'b0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            rw_q    <= RD;
            wdata_q <= '0;
            rdata_q <= '0;
            en_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata      = rdata_q;
    assign mem_en     = en_q;
    assign read_write = rw_q;
    assign address    = addr_q;
    assign data_out   = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3), directed cases plus random traffic
// checked every cycle against a transaction-level model. Honours ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        req0 [2], req1 [2], rw0 [2], rw1 [2];
    logic [11:0] addr0 [2], addr1 [2];
    logic [31:0] wdata0 [2], wdata1 [2];

    wire         ack0_w [2], ack1_w [2], mem_en_w [2], read_write_w [2];
    wire  [31:0] rdata_w [2], data_out_w [2];
    wire  [11:0] address_w [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [11:0] a);
        if (a == 12'h00A) return 32'hDEADBEEF;
        return (32'(a) * 32'h9E3779B1) ^ {a, 20'h5A5A5};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int LAT = (gi == 0) ? 1 : 3;

        logic [31:0] mem [4096];
        logic [31:0] mem_rd;
        assign mem_rd = mem[address_w[gi]];

        mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
            .clk_in(clk), .reset(reset),
            .req0(req0[gi]), .req1(req1[gi]), .rw0(rw0[gi]), .rw1(rw1[gi]),
            .addr0(addr0[gi]), .addr1(addr1[gi]), .wdata0(wdata0[gi]), .wdata1(wdata1[gi]),
            .ack0(ack0_w[gi]), .ack1(ack1_w[gi]), .rdata(rdata_w[gi]),
            .mem_en(mem_en_w[gi]), .read_write(read_write_w[gi]), .address(address_w[gi]),
            .data_out(data_out_w[gi]), .data_in(mem_rd)
        );

        // Memory model: writes land on every edge where the strobes were high.
        initial begin
            for (int a = 0; a < 4096; a++) mem[a] = init_word(12'(a));
            forever begin
                @(posedge clk);
                if (mem_en_w[gi] && read_write_w[gi]) mem[address_w[gi]] = data_out_w[gi];
            end
        end

        // Transaction-level reference: one granted access occupies phases 0..LAT+1 after its grant edge.
        logic [31:0] shadow [int];
        bit          unk [int];
        bit          busy, win, pend_unk, e_unk;
`ifdef ARB_ROUND_ROBIN_EN
        bit          fav;
`endif
        int          ph;
        logic [11:0] e_addr;
        logic        e_rw, e_en, e_a0, e_a1;
        logic [31:0] e_wd, e_rd, pend;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                if (busy && e_rw) unk[e_addr] = 1'b1;
                busy = 0; ph = 0; win = 0; pend_unk = 0; e_unk = 0;
`ifdef ARB_ROUND_ROBIN_EN
                fav = 0;
`endif
                e_addr = '0; e_rw = 1'b0; e_wd = '0; e_rd = '0; pend = '0;
                e_en = 1'b0; e_a0 = 1'b0; e_a1 = 1'b0;
            end else begin
                if (busy) begin
                    ph++;
                    if (ph == LAT + 1) busy = 0;
                end else if (req0[gi] || req1[gi]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = (req0[gi] && req1[gi]) ? fav : req1[gi];
                    fav = !win;
`else
                    win = !req0[gi];
`endif
                    busy   = 1;
                    ph     = 0;
                    e_addr = win ? addr1[gi] : addr0[gi];
                    e_rw   = win ? rw1[gi] : rw0[gi];
                    if (e_rw) begin
                        e_wd = win ? wdata1[gi] : wdata0[gi];
                        shadow[e_addr] = e_wd;
                        if (unk.exists(e_addr)) unk.delete(e_addr);
                    end else begin
                        pend     = shadow.exists(e_addr) ? shadow[e_addr] : init_word(e_addr);
                        pend_unk = unk.exists(e_addr);
                    end
                end
                e_en = busy && (ph < LAT);
                e_a0 = busy && (ph == LAT) && !win;
                e_a1 = busy && (ph == LAT) && win;
                if (busy && (ph == LAT) && !e_rw) begin
                    e_rd  = pend;
                    e_unk = pend_unk;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("L%0d mem_en", LAT), 32'(mem_en_w[gi]), 32'(e_en));
            check($sformatf("L%0d ack0", LAT), 32'(ack0_w[gi]), 32'(e_a0));
            check($sformatf("L%0d ack1", LAT), 32'(ack1_w[gi]), 32'(e_a1));
            check($sformatf("L%0d ack overlap", LAT), 32'(ack0_w[gi] & ack1_w[gi]), 32'd0);
            check($sformatf("L%0d address", LAT), 32'(address_w[gi]), 32'(e_addr));
            check($sformatf("L%0d read_write", LAT), 32'(read_write_w[gi]), 32'(e_rw));
            check($sformatf("L%0d data_out", LAT), data_out_w[gi], e_wd);
            if (reset || ((e_a0 || e_a1) && !e_rw && !e_unk))
                check($sformatf("L%0d rdata", LAT), rdata_w[gi], e_rd);
        end
    end

    task automatic do_access(input int i, input bit p, input bit rw, input logic [11:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output int lat,
                             output int en_n);
        if (!p) begin req0[i] = 1; rw0[i] = rw; addr0[i] = a; wdata0[i] = wd; end
        else    begin req1[i] = 1; rw1[i] = rw; addr1[i] = a; wdata1[i] = wd; end
        lat = -1; rd = '0; en_n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                check("grant address", 32'(address_w[i]), 32'(a));
                check("grant read_write", 32'(read_write_w[i]), 32'(rw));
                if (rw) check("grant data_out", data_out_w[i], wd);
            end
            en_n += int'(mem_en_w[i]);
            if (p ? ack1_w[i] : ack0_w[i]) begin
                lat = c;
                rd  = rdata_w[i];
                break;
            end
        end
        if (!p) req0[i] = 0; else req1[i] = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, en_n;
        int got [2][3];
        int ng [2];
        int l4 [2];
        int en5 [2], ack5 [2];
        int exp_ord [3];

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 0; req1[i] = 0; rw0[i] = 0; rw1[i] = 0;
            addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check("reset mem_en", 32'(mem_en_w[i]), 32'd0);
            check("reset ack0|ack1", 32'(ack0_w[i] | ack1_w[i]), 32'd0);
            check("reset address", 32'(address_w[i]), 32'd0);
            check("reset data_out", data_out_w[i], 32'd0);
            check("reset rdata", rdata_w[i], 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Single read, MEM_LAT=1.
        do_access(0, 0, 1'b0, 12'h00A, 32'h0, rd, lat, en_n);
        check("t1 latency", 32'(lat), 32'd2);
        check("t1 mem_en cycles", 32'(en_n), 32'd1);
        check("t1 rdata", rd, 32'hDEADBEEF);

        // Single write, MEM_LAT=3, then read it back.
        do_access(1, 1, 1'b1, 12'hFFF, 32'h12345678, rd, lat, en_n);
        check("t2 latency", 32'(lat), 32'd4);
        check("t2 mem_en cycles", 32'(en_n), 32'd3);
        do_access(1, 0, 1'b0, 12'hFFF, 32'h0, rd, lat, en_n);
        check("t2 readback", rd, 32'h12345678);

        // Reset in the second ACCESS cycle of a MEM_LAT=3 read.
        for (int i = 0; i < 2; i++) begin req0[i] = 1; rw0[i] = 0; addr0[i] = 12'h055; end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4 mid-access mem_en", 32'(mem_en_w[1]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4 async mem_en", 32'(mem_en_w[1]), 32'd0);
        check("t4 async ack0", 32'(ack0_w[1]), 32'd0);
        check("t4 async address", 32'(address_w[1]), 32'd0);
        check("t4 async data_out", data_out_w[1], 32'd0);
        check("t4 async rdata", rdata_w[1], 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        l4[0] = -1; l4[1] = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++)
                if (l4[i] < 0 && ack0_w[i]) begin l4[i] = c; req0[i] = 0; end
        end
        for (int i = 0; i < 2; i++) check("t4 post-reset latency", 32'(l4[i]), 32'(lat_of(i) + 1));

        // Contention from reset: both ports request continuously.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req0[i] = 1; rw0[i] = 0; addr0[i] = 12'h010;
            req1[i] = 1; rw1[i] = 0; addr1[i] = 12'h020;
            ng[i] = 0;
            for (int k = 0; k < 3; k++) got[i][k] = -1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        exp_ord = '{0, 1, 0};
`else
        exp_ord = '{0, 0, 0};
`endif
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (ack0_w[i] && ng[i] < 3) begin got[i][ng[i]] = 0; ng[i]++; end
                if (ack1_w[i] && ng[i] < 3) begin got[i][ng[i]] = 1; ng[i]++; end
            end
        end
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                check($sformatf("t3 L%0d grant %0d", lat_of(i), k), 32'(got[i][k]), 32'(exp_ord[k]));
        for (int i = 0; i < 2; i++) begin req0[i] = 0; req1[i] = 0; end
        repeat (6) @(posedge clk);
        #1;

        // Requester drops req in the first ACCESS cycle.
        for (int i = 0; i < 2; i++) begin req0[i] = 1; rw0[i] = 0; addr0[i] = 12'h100; end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin en5[i] = int'(mem_en_w[i]); ack5[i] = 0; req0[i] = 0; end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                en5[i]  += int'(mem_en_w[i]);
                ack5[i] += int'(ack0_w[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            check("t5 ack count", 32'(ack5[i]), 32'd1);
            check("t5 mem_en cycles", 32'(en5[i]), 32'(lat_of(i)));
        end

        // Random traffic against the model, with occasional asynchronous reset pulses.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(799) == 0) begin
                reset = 1'b1;
                #2 reset = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    logic ack, rq, nrw;
                    logic [11:0] na;
                    logic [31:0] nwd;
                    ack = (p == 0) ? ack0_w[i] : ack1_w[i];
                    rq  = (p == 0) ? req0[i] : req1[i];
                    nrw = 1'($urandom_range(1));
                    na  = ($urandom_range(3) == 0) ? 12'($urandom) : 12'($urandom_range(15));
                    nwd = $urandom;
                    if (ack || !rq) begin
                        rq = ack ? 1'($urandom_range(1)) : ($urandom_range(2) == 0);
                        if (p == 0) begin req0[i] = rq; rw0[i] = nrw; addr0[i] = na; wdata0[i] = nwd; end
                        else        begin req1[i] = rq; rw1[i] = nrw; addr1[i] = na; wdata1[i] = nwd; end
                    end else if ($urandom_range(63) == 0) begin
                        if (p == 0) req0[i] = 0; else req1[i] = 0;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
